// File: rtl/alu_pipe_if.sv
// Command/response bundle between the system controller and alu_pipe.
// The master drives operands and the command; the slave (ALU) returns results.
interface alu_pipe_if #(
  parameter int DATA_WIDTH     = 8,
  parameter int SELECTION_LINE = 4
);
  logic [DATA_WIDTH-1:0]     A;
  logic [DATA_WIDTH-1:0]     B;
  logic [SELECTION_LINE-1:0] ALU_FUN;
  logic                      Enable;
  logic                      In_Ready;
  logic [2*DATA_WIDTH-1:0]   ALU_OUT;
  logic                      OUT_Valid;
  logic                      Carry;
  logic                      Zero;
  logic                      Div_Err;

  modport master (
    output A, B, ALU_FUN, Enable,
    input  In_Ready, ALU_OUT, OUT_Valid, Carry, Zero, Div_Err
  );

  modport slave (
    input  A, B, ALU_FUN, Enable,
    output In_Ready, ALU_OUT, OUT_Valid, Carry, Zero, Div_Err
  );
endinterface

// File: rtl/alu_pipe.sv
// Pipelined ALU: single-cycle ops, full-width multiply, iterative restoring divider.
// state | meaning
// IDLE  | ready; non-divide ops and divide-by-zero complete on the accept edge
// DIV   | one restoring shift/subtract step per edge, DATA_WIDTH steps total
module alu_pipe #(
  parameter int DATA_WIDTH     = 8,
  parameter int SELECTION_LINE = 4
) (
  input logic      CLK,
  input logic      RST,
  alu_pipe_if.slave bus
);
  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(DATA_WIDTH + 1);

  typedef enum logic {IDLE, DIV} state_t;
  state_t state, state_nx;

  logic [2*W-1:0] out_q;
  logic           valid_q, carry_q, zero_q, err_q;
  logic [W-1:0]   dvd_q, dvs_q, rem_q;
  logic [CW-1:0]  cnt;

  logic           accept, legal, div_start;
  logic [3:0]     op;
  logic [W:0]     sum, diff;
  logic [2*W-1:0] op_res;
  logic           op_carry, op_err;
  logic [W:0]     rem_sh;
  logic           ge;
  logic [W-1:0]   rem_nx, quo_nx;

  assign accept    = bus.Enable && (state == IDLE);
  assign legal     = (bus.ALU_FUN >> 4) == '0;
  assign op        = bus.ALU_FUN[3:0];
  assign div_start = legal && (op == 4'b0011) && (bus.B != '0);

  // State register
  always_ff @(posedge CLK) begin
    if (!RST) state <= IDLE;
    else      state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (accept && div_start) state_nx = DIV;
      DIV:  if (cnt == CW'(W - 1))   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    bus.In_Ready = (state == IDLE);
  end

  always_comb begin
    sum      = {1'b0, bus.A} + {1'b0, bus.B};
    diff     = {1'b0, bus.A} - {1'b0, bus.B};
    op_res   = '0;
    op_carry = 1'b0;
    op_err   = 1'b0;
    if (!legal) begin
      op_err = 1'b1;
    end else begin
      case (op)
        4'b0000: begin op_res = {{(W-1){1'b0}}, sum}; op_carry = sum[W]; end
        4'b0001: begin op_res = {{W{1'b0}}, diff[W-1:0]}; op_carry = diff[W]; end
        4'b0010: op_res = {{W{1'b0}}, bus.A} * {{W{1'b0}}, bus.B};
        4'b0011: begin op_res = {bus.A, {W{1'b1}}}; op_err = 1'b1; end
        4'b0100: op_res = {{W{1'b0}}, bus.A & bus.B};
        4'b0101: op_res = {{W{1'b0}}, bus.A | bus.B};
        4'b0110: op_res = {{W{1'b0}}, ~(bus.A & bus.B)};
        4'b0111: op_res = {{W{1'b0}}, ~(bus.A | bus.B)};
        4'b1000: op_res = {{W{1'b0}}, bus.A ^ bus.B};
        4'b1001: op_res = {{W{1'b0}}, ~(bus.A ^ bus.B)};
        4'b1010: op_res = {{(2*W-1){1'b0}}, bus.A == bus.B};
        4'b1011: op_res = {{(2*W-1){1'b0}}, bus.A > bus.B};
        4'b1100: op_res = {{(2*W-1){1'b0}}, bus.A < bus.B};
        4'b1101: begin op_res = {{(W-1){1'b0}}, bus.A, 1'b0}; op_carry = bus.A[W-1]; end
        4'b1110: begin op_res = {{(W+1){1'b0}}, bus.A[W-1:1]}; op_carry = bus.A[0]; end
        default: op_err = 1'b1;
      endcase
    end
  end

  // Restoring step: the quotient bit shifts into the dividend register from the bottom
  always_comb begin
    rem_sh = {rem_q, dvd_q[W-1]};
    ge     = rem_sh >= {1'b0, dvs_q};
    rem_nx = ge ? (rem_sh[W-1:0] - dvs_q) : rem_sh[W-1:0];
    quo_nx = {dvd_q[W-2:0], ge};
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      out_q   <= '0;
      valid_q <= 1'b0;
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
      err_q   <= 1'b0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      cnt     <= '0;
    end else begin
      valid_q <= 1'b0;
      if (state == IDLE) begin
        if (accept && div_start) begin
          dvd_q <= bus.A;
          dvs_q <= bus.B;
          rem_q <= '0;
          cnt   <= '0;
        end else if (accept) begin
          out_q   <= op_res;
          carry_q <= op_carry;
          err_q   <= op_err;
          zero_q  <= (op_res == '0);
          valid_q <= 1'b1;
        end
      end else begin
        dvd_q <= quo_nx;
        rem_q <= rem_nx;
        cnt   <= cnt + 1'b1;
        if (cnt == CW'(W - 1)) begin
          out_q   <= {rem_nx, quo_nx};
          carry_q <= 1'b0;
          err_q   <= 1'b0;
          zero_q  <= ({rem_nx, quo_nx} == '0);
          valid_q <= 1'b1;
        end
      end
    end
  end

  assign bus.ALU_OUT   = out_q;
  assign bus.OUT_Valid = valid_q;
  assign bus.Carry     = carry_q;
  assign bus.Zero      = zero_q;
  assign bus.Div_Err   = err_q;
endmodule

// File: tb/tb_alu_pipe.sv
// Directed bench for alu_pipe at DATA_WIDTH=8: vector table plus divider,
// busy-ignore and reset-abort sequences.
module tb_alu_pipe;
  logic CLK = 1'b0;
  logic RST = 1'b0;
  always #5 CLK = ~CLK;

  alu_pipe_if #(.DATA_WIDTH(8), .SELECTION_LINE(4)) bus ();
  alu_pipe #(.DATA_WIDTH(8), .SELECTION_LINE(4)) dut (.CLK(CLK), .RST(RST), .bus(bus));

  typedef struct {
    logic [3:0]  fun;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] out;
    logic        c;
    logic        z;
    logic        e;
    int          lat;
  } vec_t;

  localparam int NV = 25;
  vec_t tv[NV];
  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [3:0] fun, input logic [7:0] a, input logic [7:0] b);
    bus.ALU_FUN = fun;
    bus.A       = a;
    bus.B       = b;
    bus.Enable  = 1'b1;
    n_vec++;
  endtask

  int lat, c, ir_first, v_cnt, v_cyc;
  logic [15:0] v_out;

  initial begin
    tv[0]  = '{4'h0, 8'd200, 8'd100, 16'h012C, 1'b1, 1'b0, 1'b0, 1};
    tv[1]  = '{4'h1, 8'd5,   8'd5,   16'h0000, 1'b0, 1'b1, 1'b0, 1};
    tv[2]  = '{4'h1, 8'd3,   8'd5,   16'h00FE, 1'b1, 1'b0, 1'b0, 1};
    tv[3]  = '{4'h0, 8'd0,   8'd0,   16'h0000, 1'b0, 1'b1, 1'b0, 1};
    tv[4]  = '{4'h2, 8'd255, 8'd255, 16'hFE01, 1'b0, 1'b0, 1'b0, 1};
    tv[5]  = '{4'h2, 8'd0,   8'd77,  16'h0000, 1'b0, 1'b1, 1'b0, 1};
    tv[6]  = '{4'h3, 8'd5,   8'd0,   16'h05FF, 1'b0, 1'b0, 1'b1, 1};
    tv[7]  = '{4'h4, 8'hF0,  8'h3C,  16'h0030, 1'b0, 1'b0, 1'b0, 1};
    tv[8]  = '{4'h5, 8'hF0,  8'h3C,  16'h00FC, 1'b0, 1'b0, 1'b0, 1};
    tv[9]  = '{4'h6, 8'hF0,  8'h3C,  16'h00CF, 1'b0, 1'b0, 1'b0, 1};
    tv[10] = '{4'h7, 8'hF0,  8'h3C,  16'h0003, 1'b0, 1'b0, 1'b0, 1};
    tv[11] = '{4'h8, 8'hF0,  8'h3C,  16'h00CC, 1'b0, 1'b0, 1'b0, 1};
    tv[12] = '{4'h9, 8'hF0,  8'h3C,  16'h0033, 1'b0, 1'b0, 1'b0, 1};
    tv[13] = '{4'hA, 8'd7,   8'd7,   16'h0001, 1'b0, 1'b0, 1'b0, 1};
    tv[14] = '{4'hA, 8'd7,   8'd8,   16'h0000, 1'b0, 1'b1, 1'b0, 1};
    tv[15] = '{4'hB, 8'd9,   8'd3,   16'h0001, 1'b0, 1'b0, 1'b0, 1};
    tv[16] = '{4'hC, 8'd9,   8'd3,   16'h0000, 1'b0, 1'b1, 1'b0, 1};
    tv[17] = '{4'hC, 8'd3,   8'd9,   16'h0001, 1'b0, 1'b0, 1'b0, 1};
    tv[18] = '{4'hD, 8'h81,  8'h00,  16'h0102, 1'b1, 1'b0, 1'b0, 1};
    tv[19] = '{4'hE, 8'h81,  8'h00,  16'h0040, 1'b1, 1'b0, 1'b0, 1};
    tv[20] = '{4'hE, 8'h02,  8'h00,  16'h0001, 1'b0, 1'b0, 1'b0, 1};
    tv[21] = '{4'hF, 8'h12,  8'h34,  16'h0000, 1'b0, 1'b1, 1'b1, 1};
    tv[22] = '{4'h3, 8'd255, 8'd16,  16'h0F0F, 1'b0, 1'b0, 1'b0, 9};
    tv[23] = '{4'h3, 8'd3,   8'd7,   16'h0300, 1'b0, 1'b0, 1'b0, 9};
    tv[24] = '{4'h3, 8'd200, 8'd7,   16'h041C, 1'b0, 1'b0, 1'b0, 9};

    // Reset held for two edges with a live request pending
    RST = 1'b0;
    drive(4'h0, 8'd200, 8'd100);
    repeat (2) @(negedge CLK);
    chk("rst_out",   32'(bus.ALU_OUT),   32'h0);
    chk("rst_valid", 32'(bus.OUT_Valid), 32'h0);
    chk("rst_carry", 32'(bus.Carry),     32'h0);
    chk("rst_zero",  32'(bus.Zero),      32'h0);
    chk("rst_err",   32'(bus.Div_Err),   32'h0);
    RST = 1'b1;
    bus.Enable = 1'b0;
    chk("rst_ready", 32'(bus.In_Ready), 32'h1);
    @(negedge CLK);
    chk("rst_novalid", 32'(bus.OUT_Valid), 32'h0);

    for (int i = 0; i < NV; i++) begin
      drive(tv[i].fun, tv[i].a, tv[i].b);
      @(posedge CLK);
      @(negedge CLK);
      bus.Enable = 1'b0;
      lat = 1;
      while (!bus.OUT_Valid && lat < 20) begin
        @(negedge CLK);
        lat++;
      end
      chk($sformatf("v%0d_lat", i),   32'(lat),           32'(tv[i].lat));
      chk($sformatf("v%0d_out", i),   32'(bus.ALU_OUT),   32'(tv[i].out));
      chk($sformatf("v%0d_carry", i), 32'(bus.Carry),     32'(tv[i].c));
      chk($sformatf("v%0d_zero", i),  32'(bus.Zero),      32'(tv[i].z));
      chk($sformatf("v%0d_err", i),   32'(bus.Div_Err),   32'(tv[i].e));
      @(negedge CLK);
      chk($sformatf("v%0d_pulse", i), 32'(bus.OUT_Valid), 32'h0);
    end

    // DIV 200/7 with an ADD request and operand change while busy
    drive(4'h3, 8'd200, 8'd7);
    @(posedge CLK);
    @(negedge CLK);
    bus.Enable = 1'b0;
    ir_first = 0; v_cnt = 0; v_cyc = 0; v_out = '0;
    for (c = 1; c <= 14; c++) begin
      if (bus.In_Ready && ir_first == 0) ir_first = c;
      if (bus.OUT_Valid) begin
        v_cnt++;
        v_cyc = c;
        v_out = bus.ALU_OUT;
      end
      if (c == 2) drive(4'h0, 8'd1, 8'd1);
      if (c == 3) bus.Enable = 1'b0;
      @(negedge CLK);
    end
    chk("busy_ready_cycle", 32'(ir_first), 32'd9);
    chk("busy_valid_count", 32'(v_cnt),    32'd1);
    chk("busy_valid_cycle", 32'(v_cyc),    32'd9);
    chk("busy_div_out",     32'(v_out),    32'h041C);

    // Reset at the fourth edge of a division
    drive(4'h3, 8'd200, 8'd7);
    @(posedge CLK);
    @(negedge CLK);
    bus.Enable = 1'b0;
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    chk("abort_out",   32'(bus.ALU_OUT),   32'h0);
    chk("abort_valid", 32'(bus.OUT_Valid), 32'h0);
    chk("abort_zero",  32'(bus.Zero),      32'h0);
    chk("abort_ready", 32'(bus.In_Ready),  32'h1);
    RST = 1'b1;
    v_cnt = 0;
    for (c = 0; c < 12; c++) begin
      @(negedge CLK);
      if (bus.OUT_Valid) v_cnt++;
    end
    chk("abort_no_valid", 32'(v_cnt), 32'd0);
    drive(4'h0, 8'd200, 8'd100);
    @(posedge CLK);
    @(negedge CLK);
    bus.Enable = 1'b0;
    chk("post_valid", 32'(bus.OUT_Valid), 32'h1);
    chk("post_out",   32'(bus.ALU_OUT),   32'h012C);
    chk("post_carry", 32'(bus.Carry),     32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
